// File: rtl/data_mem_arbiter_if.sv
// Requester-side handshake bundle for data_mem_arbiter.
// Port 0 is the CPU load/store stage, port 1 is the loader/debug port.
interface data_mem_arbiter_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          p0_req;
   logic          p1_req;
   logic          p0_we;
   logic          p1_we;
   logic [AW-1:0] p0_addr;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p0_wdata;
   logic [DW-1:0] p1_wdata;
   logic          p0_lock;
   logic          p1_lock;
   logic          p0_ack;
   logic          p1_ack;
   logic          p0_err;
   logic          p1_err;
   logic [DW-1:0] p0_rdata;
   logic [DW-1:0] p1_rdata;

   // Arbiter side
   modport slave (
      input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
      input  p0_wdata, p1_wdata, p0_lock, p1_lock,
      output p0_ack, p1_ack, p0_err, p1_err, p0_rdata, p1_rdata
   );

   // Requester side
   modport master (
      output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
      output p0_wdata, p1_wdata, p0_lock, p1_lock,
      input  p0_ack, p1_ack, p0_err, p1_err, p0_rdata, p1_rdata
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter: IDLE/ACCESS/DONE sequencer with round-robin
// priority, owner lock for read-modify-write, and out-of-range address rejection.
module data_mem_arbiter #(
   parameter int unsigned ADDR_LIMIT = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   data_mem_arbiter_if.slave    req_if,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [31:0]          mem_address,
   output logic [31:0]          mem_write_data,
   input  logic [31:0]          mem_read_data,
   output logic                 busy,
   output logic                 owner
);
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned NP = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic          prio_q, prio_d;
   logic          owner_q, owner_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [NP-1:0] ack_q, ack_d;
   logic [NP-1:0] err_q, err_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          busy_q, busy_d;

   logic [NP-1:0] req_c;
   logic [NP-1:0] lock_c;
   logic          locked_c;
   logic          gnt_vld_c;
   logic          gnt_c;
   logic          sel_we_c;
   logic [AW-1:0] sel_addr_c;
   logic [DW-1:0] sel_wdata_c;
   logic          oob_c;

   assign req_c  = {req_if.p1_req, req_if.p0_req};
   assign lock_c = {req_if.p1_lock, req_if.p0_lock};

   // Grant choice: a held lock pins the owner, otherwise single request or prio
   always_comb begin
      gnt_vld_c = 1'b0;
      gnt_c     = owner_q;
      locked_c  = (prio_q == owner_q) && lock_c[owner_q];
      if (locked_c) begin
         gnt_vld_c = req_c[owner_q];
      end else if (req_c == 2'b11) begin
         gnt_vld_c = 1'b1;
         gnt_c     = prio_q;
      end else if (req_c[0]) begin
         gnt_vld_c = 1'b1;
         gnt_c     = 1'b0;
      end else if (req_c[1]) begin
         gnt_vld_c = 1'b1;
         gnt_c     = 1'b1;
      end
   end

   assign sel_we_c    = gnt_c ? req_if.p1_we    : req_if.p0_we;
   assign sel_addr_c  = gnt_c ? req_if.p1_addr  : req_if.p0_addr;
   assign sel_wdata_c = gnt_c ? req_if.p1_wdata : req_if.p0_wdata;
   assign oob_c       = sel_addr_c >= AW'(ADDR_LIMIT);

   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ack_d    = '0;
      err_d    = '0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      busy_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_vld_c) begin
               owner_d = gnt_c;
               we_d    = sel_we_c;
               addr_d  = sel_addr_c;
               wdata_d = sel_wdata_c;
               busy_d  = 1'b1;
               if (oob_c) begin
                  state_d       = DONE;
                  ack_d[gnt_c]  = 1'b1;
                  err_d[gnt_c]  = 1'b1;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            state_d        = DONE;
            busy_d         = 1'b1;
            ack_d[owner_q] = 1'b1;
            if (!we_q) begin
               if (owner_q) rdata1_d = mem_read_data;
               else         rdata0_d = mem_read_data;
            end
         end
         DONE: begin
            state_d = IDLE;
            prio_d  = lock_c[owner_q] ? owner_q : ~owner_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         ack_q    <= '0;
         err_q    <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         busy_q   <= busy_d;
      end
   end

   // Memory strobes decode from state so reset drops them immediately
   assign mem_read       = (state_q == ACCESS) && !we_q;
   assign mem_write      = (state_q == ACCESS) &&  we_q;
   assign mem_address    = (state_q == ACCESS) ? addr_q  : '0;
   assign mem_write_data = (state_q == ACCESS) ? wdata_q : '0;

   assign req_if.p0_ack   = ack_q[0];
   assign req_if.p1_ack   = ack_q[1];
   assign req_if.p0_err   = err_q[0];
   assign req_if.p1_err   = err_q[1];
   assign req_if.p0_rdata = rdata0_q;
   assign req_if.p1_rdata = rdata1_q;
   assign busy            = busy_q;
   assign owner           = owner_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed scenarios plus randomized
// two-port traffic against a word-array reference memory.
module tb_data_mem_arbiter;
   localparam int unsigned ADDR_LIMIT = 256;
   localparam int unsigned WAIT_MAX   = 500;

   typedef struct packed {
      logic        err;
      logic        rd;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read, mem_write, busy, owner;
   logic [31:0] mem_address, mem_write_data, mem_read_data;

   always #5 clk = ~clk;

   data_mem_arbiter_if rif ();

   data_mem_arbiter #(.ADDR_LIMIT(ADDR_LIMIT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_if         (rif),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .busy           (busy),
      .owner          (owner)
   );

   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          wr_cnt = 0;
   exp_t        exp_q0[$];
   exp_t        exp_q1[$];
   logic [31:0] last_rd [2];
   logic [31:0] shadow [ADDR_LIMIT];
   logic [31:0] mem [ADDR_LIMIT];
   bit          mem_vld [ADDR_LIMIT];

   function automatic logic [31:0] init_val(input int unsigned a);
      return (a == 5) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(a));
   endfunction

   // Reference memory: combinational read, write on the clock edge
   assign mem_read_data = (mem_address < ADDR_LIMIT)
      ? (mem_vld[mem_address[7:0]] ? mem[mem_address[7:0]] : init_val(32'(mem_address[7:0])))
      : 32'hBAD0_BAD0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_write) wr_cnt <= wr_cnt + 1;
      if (mem_write && mem_address < ADDR_LIMIT) begin
         mem[mem_address[7:0]]     <= mem_write_data;
         mem_vld[mem_address[7:0]] <= 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic mon_port(input int p, input logic ack, input logic err, input logic [31:0] rdata);
      exp_t e;
      if (ack) begin
         if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
            n_checks++;
            $display("FAIL p%0d_unexpected_ack: got ack=1, expected no ack (cycle %0d)", p, cyc);
         end else begin
            if (p == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check($sformatf("p%0d_err", p), 32'(err), 32'(e.err));
            check($sformatf("p%0d_owner", p), 32'(owner), 32'(p));
            if (e.rd) last_rd[p] = e.data;
         end
      end
      check($sformatf("p%0d_rdata", p), rdata, last_rd[p]);
   endtask

   // Monitor: compares every ack against the scoreboard and watches strobes
   always @(negedge clk) begin
      if (!rst_n) begin
         last_rd[0] = '0;
         last_rd[1] = '0;
      end else begin
         mon_port(0, rif.p0_ack, rif.p0_err, rif.p0_rdata);
         mon_port(1, rif.p1_ack, rif.p1_err, rif.p1_rdata);
         if (rif.p0_ack || rif.p1_ack) check("ack_exclusive", 32'(rif.p0_ack & rif.p1_ack), 32'd0);
         if (mem_read || mem_write) begin
            check("one_strobe", 32'(mem_read & mem_write), 32'd0);
            check("strobe_in_range", 32'(mem_address < ADDR_LIMIT), 32'd1);
         end
      end
   end

   task automatic set_port(input int p, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic lk);
      if (p == 0) begin
         rif.p0_req = req; rif.p0_we = we; rif.p0_addr = addr; rif.p0_wdata = wdata; rif.p0_lock = lk;
      end else begin
         rif.p1_req = req; rif.p1_we = we; rif.p1_addr = addr; rif.p1_wdata = wdata; rif.p1_lock = lk;
      end
   endtask

   task automatic drop_req(input int p);
      if (p == 0) rif.p0_req = 1'b0;
      else        rif.p1_req = 1'b0;
   endtask

   task automatic drop_lock(input int p);
      if (p == 0) rif.p0_lock = 1'b0;
      else        rif.p1_lock = 1'b0;
   endtask

   // One access: push expectation, raise req, wait for ack, then step to the
   // following cycle and either keep req (hold) or drop it.
   task automatic access(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic lk, input bit hold,
                         output int t_issue, output int t_ack);
      exp_t e;
      bit   seen;
      e.err  = (addr >= ADDR_LIMIT);
      e.rd   = !we && !e.err;
      e.data = '0;
      if (!e.err) begin
         if (we) shadow[addr[7:0]] = wdata;
         e.data = shadow[addr[7:0]];
      end
      if (p == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      set_port(p, 1'b1, we, addr, wdata, lk);
      t_issue = cyc;
      t_ack   = -1;
      seen    = 1'b0;
      for (int i = 0; i < WAIT_MAX; i++) begin
         @(posedge clk); #1;
         if ((p == 0 && rif.p0_ack) || (p == 1 && rif.p1_ack)) begin
            seen  = 1'b1;
            t_ack = cyc;
            break;
         end
      end
      check($sformatf("p%0d_ack_seen", p), 32'(seen), 32'd1);
      @(posedge clk); #1;
      if (!hold) drop_req(p);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_port(0, 1'b0, 1'b0, '0, '0, 1'b0);
      set_port(1, 1'b0, 1'b0, '0, '0, 1'b0);
      @(posedge clk); #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_acks", 32'({rif.p1_ack, rif.p0_ack}), 32'd0);
      check("rst_errs", 32'({rif.p1_err, rif.p0_err}), 32'd0);
      check("rst_strobes", 32'({mem_write, mem_read}), 32'd0);
      check("rst_mem_address", mem_address, 32'd0);
      check("rst_mem_wdata", mem_write_data, 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_p0_rdata", rif.p0_rdata, 32'd0);
      check("rst_p1_rdata", rif.p1_rdata, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic rand_port(input int p, input int n);
      for (int k = 0; k < n; k++) begin
         logic [31:0] a;
         logic        we;
         logic        lk;
         int          gap;
         int          ti;
         int          ta;
         gap = int'($urandom_range(0, 2));
         if ($urandom_range(0, 7) == 0)
            a = ($urandom_range(0, 1) == 1) ? (32'h8000_0000 | $urandom)
                                            : 32'(ADDR_LIMIT + $urandom_range(0, 1000));
         else
            a = 32'(2 * $urandom_range(0, 127) + p);
         we = ($urandom_range(0, 1) == 1);
         lk = ($urandom_range(0, 3) == 0);
         access(p, we, a, $urandom, lk, (gap == 0) && (k < n - 1), ti, ta);
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      drop_lock(p);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ti0, ta0, ti1, ta1, t_start, wr0;
      int c0 [4];
      int c1 [4];
      logic [31:0] hold_rd;
      for (int i = 0; i < int'(ADDR_LIMIT); i++) shadow[i] = init_val(32'(i));

      do_reset();

      // Single read of a preloaded word, strobe expected one cycle after request
      fork
         access(0, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, ti0, ta0);
         begin
            @(posedge clk); #1;
            check("single_rd_strobe", 32'({mem_write, mem_read}), 32'b01);
            check("single_rd_addr", mem_address, 32'd5);
         end
      join
      check("single_rd_latency", 32'(ta0 - ti0), 32'd2);
      check("single_rd_data", rif.p0_rdata, 32'hDEAD_BEEF);

      // Write then read back on port 1, back to back
      wr0 = wr_cnt;
      access(1, 1'b1, 32'd10, 32'h1234_5678, 1'b0, 1'b1, ti1, ta1);
      t_start = ti1;
      access(1, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0, ti1, ta1);
      check("wr_rd_ack_cycle", 32'(ta1 - t_start), 32'd5);
      check("wr_strobe_cycles", 32'(wr_cnt - wr0), 32'd1);
      check("wr_rd_data", rif.p1_rdata, 32'h1234_5678);

      // Contention from reset: strict alternation, acks every 3 cycles
      do_reset();
      t_start = cyc;
      fork
         for (int k = 0; k < 4; k++) begin
            access(0, (k % 2) == 1, 32'(20 + 2 * k), $urandom, 1'b0, k < 3, ti0, ta0);
            c0[k] = ta0 - t_start;
         end
         for (int k = 0; k < 4; k++) begin
            access(1, (k % 2) == 0, 32'(21 + 2 * k), $urandom, 1'b0, k < 3, ti1, ta1);
            c1[k] = ta1 - t_start;
         end
      join
      for (int k = 0; k < 4; k++) begin
         check($sformatf("contend_p0_ack%0d", k), 32'(c0[k]), 32'(2 + 6 * k));
         check($sformatf("contend_p1_ack%0d", k), 32'(c1[k]), 32'(5 + 6 * k));
      end

      // Lock: p1 keeps ownership for three accesses, then releases to p0
      do_reset();
      t_start = cyc;
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               access(1, 1'b0, 32'(31 + 2 * k), 32'd0, 1'b1, k < 2, ti1, ta1);
               c1[k] = ta1 - t_start;
            end
            drop_lock(1);
         end
         begin
            @(posedge clk); #1;
            access(0, 1'b1, 32'd30, 32'hA5A5_0030, 1'b0, 1'b0, ti0, ta0);
            c0[0] = ta0 - t_start;
         end
      join
      for (int k = 0; k < 3; k++) check($sformatf("lock_p1_ack%0d", k), 32'(c1[k]), 32'(2 + 3 * k));
      check("lock_release_p0_ack", 32'(c0[0]), 32'd11);

      // Range check: limit rejected without strobe, limit-1 accepted
      hold_rd = rif.p0_rdata;
      access(0, 1'b0, 32'(ADDR_LIMIT), 32'd0, 1'b0, 1'b0, ti0, ta0);
      check("oob_latency", 32'(ta0 - ti0), 32'd1);
      check("oob_rdata_kept", rif.p0_rdata, hold_rd);
      access(0, 1'b1, 32'hFFFF_FFFF, 32'h0BAD_0BAD, 1'b0, 1'b0, ti0, ta0);
      check("oob_max_latency", 32'(ta0 - ti0), 32'd1);
      access(1, 1'b0, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0, ti1, ta1);
      check("oob_p1_latency", 32'(ta1 - ti1), 32'd1);
      access(0, 1'b0, 32'(ADDR_LIMIT - 1), 32'd0, 1'b0, 1'b0, ti0, ta0);
      check("edge_latency", 32'(ta0 - ti0), 32'd2);
      check("edge_rdata", rif.p0_rdata, init_val(ADDR_LIMIT - 1));

      // Reset during ACCESS: strobe and busy drop at once, no ack afterwards
      set_port(0, 1'b1, 1'b1, 32'd100, shadow[100], 1'b0);
      @(posedge clk); #1;
      check("mid_rst_write_active", 32'(mem_write), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_strobe", 32'({mem_write, mem_read}), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ack", 32'({rif.p1_ack, rif.p0_ack}), 32'd0);
      set_port(0, 1'b0, 1'b0, '0, '0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("post_rst_no_ack", 32'({rif.p1_ack, rif.p0_ack}), 32'd0);
         check("post_rst_busy", 32'(busy), 32'd0);
      end
      t_start = cyc;
      fork
         begin access(0, 1'b0, 32'd40, 32'd0, 1'b0, 1'b0, ti0, ta0); c0[0] = ta0 - t_start; end
         begin access(1, 1'b0, 32'd41, 32'd0, 1'b0, 1'b0, ti1, ta1); c1[0] = ta1 - t_start; end
      join
      check("post_rst_prio_p0", 32'(c0[0]), 32'd2);
      check("post_rst_prio_p1", 32'(c1[0]), 32'd5);

      // Randomized traffic on disjoint address halves (p0 even, p1 odd)
      fork
         rand_port(0, 40);
         rand_port(1, 40);
      join

      repeat (5) @(posedge clk);
      #1;
      check("drain_q0", 32'(exp_q0.size()), 32'd0);
      check("drain_q1", 32'(exp_q1.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
